ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - March-style write/read-back BIST sequencer for a 1024x8 async-read RAM
// Optional inverted-pattern pass enabled by defining RAM_BIST_INV_PASS_EN.
module ram_bist_ctrl #(
  parameter int                ADDR_W = 10,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR     = 3'd1;
  localparam logic [2:0] RD     = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
`ifdef RAM_BIST_INV_PASS_EN
  localparam logic [2:0] WR_INV = 3'd4;
  localparam logic [2:0] RD_INV = 3'd5;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   ERR_MAX   = '1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              pass_q, pass_d;

  logic [DATA_W-1:0] pat;
  logic              last;
  logic              cmp_en;
  logic [DATA_W-1:0] cmp_exp;
  logic              mismatch;

  // Address-derived pattern and compare selection for the current read pass
  always_comb begin
    pat      = cnt_q[DATA_W-1:0] ^ SEED;
    last     = (cnt_q == LAST_ADDR);
    cmp_en   = 1'b0;
    cmp_exp  = pat;
    if (state_q == RD) begin
      cmp_en  = 1'b1;
      cmp_exp = pat;
    end
`ifdef RAM_BIST_INV_PASS_EN
    if (state_q == RD_INV) begin
      cmp_en  = 1'b1;
      cmp_exp = ~pat;
    end
`endif
    mismatch = cmp_en && (mem_dout != cmp_exp);
  end

  // Next-state, counter and result accumulation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    // Error accounting is shared by every read pass so the first failing
    // address and the count span both passes when the inverted pass runs.
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        fail_d = cnt_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WR;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      WR: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = RD;
        end
      end
      RD: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
`ifdef RAM_BIST_INV_PASS_EN
          state_d = WR_INV;
`else
          state_d = DONE;
          pass_d  = (err_d == '0);
`endif
        end
      end
`ifdef RAM_BIST_INV_PASS_EN
      WR_INV: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = RD_INV;
        end
      end
      RD_INV: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and result registers; reset aborts any test in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // RAM-side and status outputs decode from registered state only
  always_comb begin
    mem_addr = cnt_q;
    mem_din  = '0;
    mem_w_en = 1'b0;
    busy     = 1'b0;
    done     = (state_q == DONE);
    case (state_q)
      WR: begin
        mem_din  = pat;
        mem_w_en = 1'b1;
        busy     = 1'b1;
      end
      RD: begin
        busy = 1'b1;
      end
`ifdef RAM_BIST_INV_PASS_EN
      WR_INV: begin
        mem_din  = ~pat;
        mem_w_en = 1'b1;
        busy     = 1'b1;
      end
      RD_INV: begin
        busy = 1'b1;
      end
`endif
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - directed bench for ram_bist_ctrl with a behavioural async-read RAM
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int TOTAL     = 4096;
  localparam int STUCK_ERR = 1024;
`else
  localparam int TOTAL     = 2048;
  localparam int STUCK_ERR = 512;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_din;
  logic        mem_w_en;
  logic [7:0]  mem_dout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [10:0] err_cnt;
  logic [9:0]  fail_addr;

  logic [7:0]  ram [1024];
  logic        stuck0;

  int checks;
  int errors;

  ram_bist_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_w_en  (mem_w_en),
    .mem_dout  (mem_dout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_din;
  end

  assign mem_dout = stuck0 ? (ram[mem_addr] & 8'hFE) : ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait at negedges until done; counts busy samples; optional backdoor corruption once RD begins
  task automatic wait_done(input bit corrupt, output int nbusy);
    bit hit;
    hit   = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done) break;
      if (busy) nbusy++;
      if (corrupt && !hit && busy && !mem_w_en) begin
        ram[444] = 8'h00;
        hit = 1'b1;
      end
      @(negedge clk);
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int  nb;
  bit  wen_seen;
  bit  outs_nz;

  initial begin
    checks = 0;
    errors = 0;
    stuck0 = 1'b0;
    start  = 1'b0;
    rst_n  = 1'b0;
    #23;
    rst_n  = 1'b1;

    // 1. reset and idle
    wen_seen = 1'b0;
    outs_nz  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_w_en) wen_seen = 1'b1;
      if (busy || done || pass || err_cnt != 0 || fail_addr != 0 || mem_addr != 0 || mem_din != 0)
        outs_nz = 1'b1;
    end
    check("idle_w_en", {31'd0, wen_seen}, 32'd0);
    check("idle_outs", {31'd0, outs_nz}, 32'd0);

    // 2. good RAM
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(1'b0, nb);
    check("good_busy_cycles", nb, TOTAL);
    check("good_pass", {31'd0, pass}, 32'd1);
    check("good_err", {21'd0, err_cnt}, 32'd0);
    check("good_busy_low", {31'd0, busy}, 32'd0);
`ifdef RAM_BIST_INV_PASS_EN
    check("bd_1010", {24'd0, ram[1010]}, 32'hA8);
    check("bd_444", {24'd0, ram[444]}, 32'hE6);
`else
    check("bd_1010", {24'd0, ram[1010]}, 32'h57);
    check("bd_444", {24'd0, ram[444]}, 32'h19);
`endif
    repeat (3) @(negedge clk);
    check("done_held", {31'd0, done}, 32'd1);
    check("pass_held", {31'd0, pass}, 32'd1);

    // 3. stuck-at-0 on bit 0
    stuck0 = 1'b1;
    pulse_start();
    wait_done(1'b0, nb);
    check("stuck_err", {21'd0, err_cnt}, STUCK_ERR);
    check("stuck_fail_addr", {22'd0, fail_addr}, 32'd0);
    check("stuck_pass", {31'd0, pass}, 32'd0);
    stuck0 = 1'b0;

    // 4. single corruption at 444 after write phase
    pulse_start();
    wait_done(1'b1, nb);
    check("corrupt_err", {21'd0, err_cnt}, 32'd1);
    check("corrupt_fail_addr", {22'd0, fail_addr}, 32'd444);
    check("corrupt_pass", {31'd0, pass}, 32'd0);

    // 5. start held high: no restart while busy, restart from DONE clears results
    stuck0 = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, nb);
    check("held_busy_cycles", nb, TOTAL);
    check("held_err", {21'd0, err_cnt}, STUCK_ERR);
    stuck0 = 1'b0;
    @(negedge clk);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_done_low", {31'd0, done}, 32'd0);
    check("restart_err_clr", {21'd0, err_cnt}, 32'd0);
    start = 1'b0;
    wait_done(1'b0, nb);
    check("restart_pass", {31'd0, pass}, 32'd1);
    check("restart_err", {21'd0, err_cnt}, 32'd0);

    // 6. reset mid-test at mem_addr 300 during WR
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (mem_w_en && mem_addr == 10'd300) break;
      @(negedge clk);
    end
    check("reached_300", {21'd0, mem_w_en, mem_addr}, {21'd0, 1'b1, 10'd300});
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_outs", {busy, done, pass, mem_w_en, err_cnt, fail_addr, mem_addr, mem_din},
          '0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_done(1'b0, nb);
    check("post_rst_cycles", nb, TOTAL);
    check("post_rst_pass", {31'd0, pass}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
